mem_bus_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single 16-bit memory bus between the data cache/LSU (master 0) and the instruction cache line-fill engine (master 1). It sits between both cache controllers and the external memory interface. Ownership is granted per bus cycle: a master keeps the bus for its whole `cyc` window, so an 8-beat icache line burst is never split. A watchdog terminates stalled transfers with a synthesized error.

---
 rtl/mem_bus_arbiter_pkg.sv | 31 +++
 rtl/mem_bus_arbiter_if.sv | 29 ++
 rtl/mem_bus_arbiter_watchdog.sv | 39 +++
 rtl/mem_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM state
// encoding, watchdog counter type and the grant-selection helper.
package mem_bus_arbiter_pkg;

  localparam int ARB_RW = 16;
  localparam int WD_W   = 8;

  typedef logic [WD_W-1:0] wd_cnt_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  // Picks the next owner from the live cyc requests. On a tie, prefer1
  // decides; with fixed priority it is tied low so master 0 always wins.
  function automatic arb_state_e arb_pick(input logic req0,
                                          input logic req1,
                                          input logic prefer1);
    arb_state_e pick;
    pick = ARB_IDLE;
    if (req0 && (!req1 || !prefer1)) begin
      pick = ARB_OWN0;
    end else if (req1) begin
      pick = ARB_OWN1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Wishbone-style bus bundle used for both cache-side masters and the shared
// memory slave port; o_dat is always write data, i_dat always read data.
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int RW = ARB_RW
);

  logic            cyc;
  logic            stb;
  logic            we;
  logic [RW-1:0]   adr;
  logic [RW-1:0]   o_dat;
  logic [RW/8-1:0] sel;
  logic            ack;
  logic            err;
  logic [RW-1:0]   i_dat;

  modport master (
    output cyc, stb, we, adr, o_dat, sel,
    input  ack, err, i_dat
  );

  modport slave (
    input  cyc, stb, we, adr, o_dat, sel,
    output ack, err, i_dat
  );

endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// bus_watchdog: counts consecutive wait states of the transfer in progress
// and raises a one-cycle wd_err once the count reaches TIMEOUT.
module bus_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic busy,
  input  logic done,
  input  logic restart,
  output logic wd_err
);

  localparam wd_cnt_t LIMIT = wd_cnt_t'(TIMEOUT);

  wd_cnt_t wd_cnt_q, wd_cnt_d;

  assign wd_err = busy && (wd_cnt_q == LIMIT);

  // NOTE: every always_comb output is given a default first, so no branch can leave it unassigned and infer a latch.
  always_comb begin
    wd_cnt_d = wd_cnt_q + wd_cnt_t'(1);
    if (restart || done || !busy || wd_err) begin
      wd_cnt_d = '0;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the pre-edge value of its inputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter (dcache = m0, icache fill = m1) with per-cyc
// ownership and a wait-state watchdog. Define ARB_ROUND_ROBIN_EN for round-robin ties.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int RW      = ARB_RW,
  parameter int TIMEOUT = 255
) (
  input logic               i_clk,
  input logic               i_rst,
  mem_bus_arbiter_if.slave  m0_bus,
  mem_bus_arbiter_if.slave  m1_bus,
  mem_bus_arbiter_if.master s_bus
);

  localparam logic [RW-1:0] DAT_ZERO = '0;

  arb_state_e state_q, state_d;
  logic       prefer1;
  logic       wd_busy;
  logic       wd_done;
  logic       wd_restart;
  logic       wd_err;

  // ---------------------------------------------------------------------------
  // Tie-break selection
  // ---------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_d == ARB_OWN0 && state_q != ARB_OWN0) begin
      last_d = 1'b0;
    end else if (state_d == ARB_OWN1 && state_q != ARB_OWN1) begin
      last_d = 1'b1;
    end
  end

  // Resetting to 1 lets master 0 win the first tie after reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign prefer1 = ~last_q;
`else
  assign prefer1 = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Ownership FSM: the owner keeps the bus until its own cyc drops
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: state_d = arb_pick(m0_bus.cyc, m1_bus.cyc, prefer1);
      ARB_OWN0: if (!m0_bus.cyc) state_d = arb_pick(1'b0, m1_bus.cyc, prefer1);
      ARB_OWN1: if (!m1_bus.cyc) state_d = arb_pick(m0_bus.cyc, 1'b0, prefer1);
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  assign wd_busy    = ((state_q == ARB_OWN0) && m0_bus.stb) ||
                      ((state_q == ARB_OWN1) && m1_bus.stb);
  assign wd_done    = s_bus.ack | s_bus.err;
  assign wd_restart = (state_d != state_q);

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .busy    (wd_busy),
    .done    (wd_done),
    .restart (wd_restart),
    .wd_err  (wd_err)
  );

  // ---------------------------------------------------------------------------
  // Request path: slave side follows the registered owner; stb is masked on a
  // watchdog error so the stalled slave never sees a fresh strobe that cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_bus.cyc   = 1'b0;
    s_bus.stb   = 1'b0;
    s_bus.we    = 1'b0;
    s_bus.adr   = DAT_ZERO;
    s_bus.o_dat = DAT_ZERO;
    s_bus.sel   = '0;
    unique case (state_q)
      ARB_OWN0: begin
        s_bus.cyc   = m0_bus.cyc;
        s_bus.stb   = m0_bus.stb & ~wd_err;
        s_bus.we    = m0_bus.we;
        s_bus.adr   = m0_bus.adr;
        s_bus.o_dat = m0_bus.o_dat;
        s_bus.sel   = m0_bus.sel;
      end
      ARB_OWN1: begin
        s_bus.cyc   = m1_bus.cyc;
        s_bus.stb   = m1_bus.stb & ~wd_err;
        s_bus.we    = m1_bus.we;
        s_bus.adr   = m1_bus.adr;
        s_bus.o_dat = m1_bus.o_dat;
        s_bus.sel   = m1_bus.sel;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response path: terminations reach only the owner; slave responses while
  // idle are dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    m0_bus.ack   = 1'b0;
    m0_bus.err   = 1'b0;
    m0_bus.i_dat = DAT_ZERO;
    m1_bus.ack   = 1'b0;
    m1_bus.err   = 1'b0;
    m1_bus.i_dat = DAT_ZERO;
    unique case (state_q)
      ARB_OWN0: begin
        m0_bus.ack   = s_bus.ack;
        m0_bus.err   = s_bus.err | wd_err;
        m0_bus.i_dat = s_bus.i_dat;
        m1_bus.i_dat = s_bus.i_dat;
      end
      ARB_OWN1: begin
        m1_bus.ack   = s_bus.ack;
        m1_bus.err   = s_bus.err | wd_err;
        m0_bus.i_dat = s_bus.i_dat;
        m1_bus.i_dat = s_bus.i_dat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a cycle table for arbitration and
// handover, then hand-written burst, watchdog, slave-error, reset and tie sequences.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int          RW      = 16;
  localparam int          TIMEOUT = 4;
  localparam logic [15:0] M0_ADR  = 16'h1234;
  localparam logic [15:0] M0_DAT  = 16'hD00D;
  localparam logic [15:0] M1_ADR  = 16'h2000;
  localparam logic [15:0] M1_DAT  = 16'hBEEF;
  localparam logic [15:0] RD_KEY  = 16'h5A5A;
  localparam int          NV      = 14;

  // in_bits : {m0_cyc, m0_stb, m1_cyc, m1_stb, slave_ack_en, slave_err_en, slave_force}
  // exp_bits: {s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err}
  // mux     : which master the slave bus follows (0 none, 1 m0, 2 m1)
  typedef struct packed {
    logic [6:0] in_bits;
    logic [5:0] exp_bits;
    logic [1:0] mux;
  } vec_t;

  logic i_clk;
  logic i_rst;
  logic slv_ack_en, slv_err_en, slv_force;
  int   n_checks, n_errors;

  mem_bus_arbiter_if #(.RW(RW)) m0_if ();
  mem_bus_arbiter_if #(.RW(RW)) m1_if ();
  mem_bus_arbiter_if #(.RW(RW)) s_if ();

  mem_bus_arbiter #(
    .RW      (RW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .m0_bus (m0_if),
    .m1_bus (m1_if),
    .s_bus  (s_if)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Zero-wait slave model; slv_force drives ack/err regardless of the bus.
  always_comb begin
    s_if.ack   = slv_force | (slv_ack_en & ~slv_err_en & s_if.cyc & s_if.stb);
    s_if.err   = slv_force | (slv_err_en & s_if.cyc & s_if.stb);
    s_if.i_dat = s_if.adr ^ RD_KEY;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exhausted");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_m0(input logic cyc, input logic stb);
    m0_if.cyc = cyc;
    m0_if.stb = stb;
  endtask

  task automatic set_m1(input logic cyc, input logic stb);
    m1_if.cyc = cyc;
    m1_if.stb = stb;
  endtask

  task automatic drop_all();
    @(negedge i_clk);
    set_m0(1'b0, 1'b0);
    set_m1(1'b0, 1'b0);
    m1_if.adr  = M1_ADR;
    slv_err_en = 1'b0;
    slv_force  = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
  endtask

  vec_t        vecs [NV];
  vec_t        v;
  logic [15:0] exp_adr, exp_wdat, exp_rd;
  logic [1:0]  exp_sel;
  logic        exp_we;
  logic [31:0] exp_v;
  int          ack_cnt;
  logic        other_seen;
  logic        exp_w;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    i_rst      = 1'b0;
    slv_ack_en = 1'b0;
    slv_err_en = 1'b0;
    slv_force  = 1'b0;
    set_m0(1'b0, 1'b0);
    set_m1(1'b0, 1'b0);
    m0_if.we = 1'b1; m0_if.adr = M0_ADR; m0_if.o_dat = M0_DAT; m0_if.sel = 2'b01;
    m1_if.we = 1'b0; m1_if.adr = M1_ADR; m1_if.o_dat = M1_DAT; m1_if.sel = 2'b11;

    vecs[0]  = {7'b0000000, 6'b000000, 2'd0};
    vecs[1]  = {7'b1111000, 6'b000000, 2'd0};  // tie from reset
    vecs[2]  = {7'b1111100, 6'b111000, 2'd1};  // master 0 wins
    vecs[3]  = {7'b0011100, 6'b000000, 2'd1};  // m0 drops: dead cycle
    vecs[4]  = {7'b1111100, 6'b110010, 2'd2};  // m1 owns, m0 waits
    vecs[5]  = {7'b1111100, 6'b110010, 2'd2};
    vecs[6]  = {7'b1100100, 6'b000000, 2'd2};  // m1 drops: dead cycle
    vecs[7]  = {7'b1100010, 6'b110100, 2'd1};  // slave error to m0
    vecs[8]  = {7'b0000000, 6'b000000, 2'd1};
    vecs[9]  = {7'b0000001, 6'b000000, 2'd0};  // stray ack/err while idle
    vecs[10] = {7'b0011000, 6'b000000, 2'd0};
    vecs[11] = {7'b0011100, 6'b110010, 2'd2};
    vecs[12] = {7'b0000000, 6'b000000, 2'd2};
    vecs[13] = {7'b0000000, 6'b000000, 2'd0};

    // Outputs during reset, with requests and stray slave responses present.
    @(negedge i_clk);
    set_m0(1'b1, 1'b1);
    slv_force = 1'b1;
    #1;
    check("reset_ctl", 32'({s_if.cyc, s_if.stb, m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}), 32'(0));
    check("reset_rdata", 32'({m0_if.i_dat, m1_if.i_dat}), 32'(0));
    set_m0(1'b0, 1'b0);
    slv_force = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;

    // Cycle table
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge i_clk);
      {m0_if.cyc, m0_if.stb, m1_if.cyc, m1_if.stb, slv_ack_en, slv_err_en, slv_force} = v.in_bits;
      #1;
      exp_adr  = (v.mux == 2'd1) ? M0_ADR : (v.mux == 2'd2) ? M1_ADR : 16'h0;
      exp_wdat = (v.mux == 2'd1) ? M0_DAT : (v.mux == 2'd2) ? M1_DAT : 16'h0;
      exp_sel  = (v.mux == 2'd1) ? 2'b01  : (v.mux == 2'd2) ? 2'b11  : 2'b00;
      exp_we   = (v.mux == 2'd1);
      exp_rd   = (v.mux != 2'd0) ? (exp_adr ^ RD_KEY) : 16'h0;
      check($sformatf("vec%0d_ctl", i),
            32'({s_if.cyc, s_if.stb, s_if.we, s_if.sel, m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}),
            32'({v.exp_bits[5:4], exp_we, exp_sel, v.exp_bits[3:0]}));
      check($sformatf("vec%0d_req", i), {s_if.adr, s_if.o_dat}, {exp_adr, exp_wdat});
      check($sformatf("vec%0d_rdata", i), {m0_if.i_dat, m1_if.i_dat}, {exp_rd, exp_rd});
    end
    drop_all();

    // Single master-1 burst, 8 reads, zero-wait slave.
    @(negedge i_clk);
    slv_ack_en = 1'b1;
    set_m1(1'b1, 1'b1);
    #1;
    check("burst_idle_cycle", 32'(s_if.cyc), 32'(0));
    ack_cnt    = 0;
    other_seen = 1'b0;
    for (int b = 0; b < 8; b++) begin
      @(negedge i_clk);
      m1_if.adr = M1_ADR + 16'(2 * b);
      #1;
      if (b == 0) check("burst_grant", 32'(s_if.cyc), 32'(1));
      check($sformatf("burst_adr%0d", b), 32'(s_if.adr), 32'(M1_ADR + 16'(2 * b)));
      ack_cnt    += int'(m1_if.ack);
      other_seen |= m0_if.ack | m0_if.err;
    end
    check("burst_acks", ack_cnt, 8);
    check("burst_m0_quiet", 32'(other_seen), 32'(0));
    drop_all();

    // Burst atomicity: m0 requests mid-burst, handover after one dead cycle.
    @(negedge i_clk);
    set_m1(1'b1, 1'b1);
    for (int b = 0; b < 8; b++) begin
      @(negedge i_clk);
      m1_if.adr = M1_ADR + 16'(2 * b);
      if (b == 3) set_m0(1'b1, 1'b1);
      #1;
      if (b >= 3)
        check($sformatf("atom_hold%0d", b), 32'({m0_if.ack, m0_if.err, m1_if.ack, s_if.adr}),
              32'({2'b00, 1'b1, M1_ADR + 16'(2 * b)}));
    end
    @(negedge i_clk);
    set_m1(1'b0, 1'b0);
    #1;
    check("atom_dead", 32'({s_if.cyc, m0_if.ack, m1_if.ack}), 32'(0));
    @(negedge i_clk);
    #1;
    check("atom_handover", 32'({s_if.cyc, m0_if.ack, s_if.adr}), 32'({2'b11, M0_ADR}));
    drop_all();

    // Watchdog: slave never acks, TIMEOUT = 4.
    @(negedge i_clk);
    slv_ack_en = 1'b0;
    set_m0(1'b1, 1'b1);
    for (int w = 1; w <= 6; w++) begin
      @(negedge i_clk);
      #1;
      check($sformatf("wd_wait%0d", w), 32'({s_if.cyc, s_if.stb, m0_if.err, m1_if.err}),
            32'({1'b1, w != 5, w == 5, 1'b0}));
    end
    drop_all();

    // Slave error on beat 3 of an m1 burst, m0 pending.
    @(negedge i_clk);
    slv_ack_en = 1'b1;
    set_m1(1'b1, 1'b1);
    for (int b = 0; b < 4; b++) begin
      @(negedge i_clk);
      m1_if.adr  = M1_ADR + 16'(2 * b);
      if (b == 1) set_m0(1'b1, 1'b1);
      slv_err_en = (b == 3);
      #1;
      check($sformatf("serr_beat%0d", b), 32'({m1_if.ack, m1_if.err, m0_if.ack, m0_if.err}),
            (b == 3) ? 32'h4 : 32'h8);
    end
    @(negedge i_clk);
    slv_err_en = 1'b0;
    set_m1(1'b0, 1'b0);
    #1;
    check("serr_dead", 32'(s_if.cyc), 32'(0));
    @(negedge i_clk);
    #1;
    check("serr_m0_grant", 32'({s_if.cyc, m0_if.ack, s_if.adr}), 32'({2'b11, M0_ADR}));
    drop_all();

    // Asynchronous reset between clock edges mid-burst.
    @(negedge i_clk);
    set_m1(1'b1, 1'b1);
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    check("rst_pre", 32'({s_if.cyc, s_if.stb, m1_if.ack}), 32'(3'b111));
    #2;
    i_rst = 1'b0;
    #1;
    check("rst_async", 32'({s_if.cyc, s_if.stb, m1_if.ack, m1_if.err, m0_if.ack, m0_if.err}), 32'(0));
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("rst_release_idle", 32'(s_if.cyc), 32'(0));
    @(negedge i_clk);
    #1;
    check("rst_regrant", 32'({s_if.cyc, m1_if.ack}), 32'(2'b11));
    drop_all();

    // Repeated ties from a fresh reset.
    @(negedge i_clk);
    i_rst = 1'b0;
    #2;
    i_rst = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge i_clk);
      set_m0(1'b1, 1'b1);
      set_m1(1'b1, 1'b1);
      @(negedge i_clk);
      #1;
`ifdef ARB_ROUND_ROBIN_EN
      exp_w = r[0];
`else
      exp_w = 1'b0;
`endif
      exp_v = exp_w ? 32'({M1_ADR, 2'b01}) : 32'({M0_ADR, 2'b10});
      check($sformatf("tie_round%0d", r), 32'({s_if.adr, m0_if.ack, m1_if.ack}), exp_v);
      @(negedge i_clk);
      set_m0(1'b0, 1'b0);
      set_m1(1'b0, 1'b0);
      @(negedge i_clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
